div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand width; result width is 2*DATA_WIDTH.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 signed_div_input  input  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled at start.
REQ-006 opdata1_input  input  32  dividend; sampled at start.
REQ-007 opdata2_input  input  32  divisor; sampled at start.
REQ-008 start_input  input  1  request from EX; held high until result is consumed.
REQ-009 annul_input  input  1  abort current operation (branch-delay/flush cancel).
REQ-010 result_output  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-011 ready_output  output  1  result_output valid.
REQ-012 busy_output  output  1  operation in progress; EX uses it for its stall request.

Function
REQ-013 The FSM SHALL have states IDLE, BY_ZERO, ON, END.
REQ-014 In IDLE, with start_input=1 and annul_input=0: if opdata2_input==0, go to BY_ZERO; else go to ON, latch operands, clear the iteration counter.
REQ-015 On entry to ON, signed mode SHALL replace negative operands with their two's-complement magnitudes; unsigned mode uses raw values.
REQ-016 ON SHALL perform one restoring shift-subtract step per cycle on a 65-bit {partial remainder, quotient} register: subtract the divisor from the upper 33 bits; if the result is non-negative, keep the difference and shift in 1; otherwise shift in 0.
REQ-017 After exactly 32 steps, ON SHALL go to END.
REQ-018 On the ON->END transition, result_output SHALL be registered with sign correction: quotient negated if signed and operand signs differ; remainder negated if signed and dividend negative.
REQ-019 BY_ZERO SHALL go to END on the next cycle with result_output = 0.
REQ-020 ready_output SHALL be 1 exactly while in END; result_output SHALL hold stable in END.
REQ-021 END SHALL stay in END while start_input=1 and go to IDLE on the cycle after start_input=0; ready_output and result_output clear on that transition.
REQ-022 busy_output SHALL be 1 in ON and BY_ZERO and 0 otherwise.
REQ-023 Latency: start accepted at cycle T -> ready_output=1 at T+33 (nonzero divisor) or T+2 (zero divisor).
REQ-024 annul_input=1 in ON or BY_ZERO SHALL return the FSM to IDLE next cycle, with ready_output never asserted for that operation.
REQ-025 annul_input=1 in IDLE SHALL take priority over start_input, and the FSM stays in IDLE.
REQ-026 Changes to operand inputs after acceptance SHALL have no effect on the operation in flight.
REQ-027 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no exception signalled.

Reset
REQ-028 On reset: state=IDLE, counter=0, result_output=0, ready_output=0, busy_output=0.
REQ-029 Reset SHALL take priority over all inputs, including mid-operation, and the aborted operation produces no ready pulse.

Structure
REQ-030 The state encodings (DivFree, DivByZero, DivOn, DivEnd), DATA_WIDTH, DivResultReady/NotReady and DivStart/Stop constants SHALL live in the shared defines file.
REQ-031 One combinational sub-module, div_step, SHALL implement a single 33-bit subtract/compare/shift iteration; the FSM, counter and sign correction stay in div_unit.
REQ-032 The implementation SHALL contain no combinational divide operator.

Verification
REQ-033 Unsigned 100 / 7, start at T -> ready_output at T+33, result_output = {0x00000002, 0x0000000E}.
REQ-034 Signed 0xFFFFFFF9 (-7) / 2 -> result_output = {0xFFFFFFFF, 0xFFFFFFFD}; the same operands unsigned -> {0x00000001, 0x7FFFFFFC}.
REQ-035 Any / 0 -> busy_output for 1 cycle, ready_output at T+2, result_output = 0; deassert start -> IDLE next cycle.
REQ-036 annul_input pulsed at step 10 of 12345 / 3 -> IDLE next cycle, ready_output stays 0; an immediate new start 9 / 3 -> {0, 3} at T'+33.
REQ-037 reset asserted at step 20 -> all outputs 0 next cycle; a following start 0x80000000 / 0xFFFFFFFF signed -> {0x00000000, 0x80000000}.
REQ-038 start_input held 5 cycles in END -> ready_output and result_output stable for all 5; clear on the cycle after start drops.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the iterative divider.
package div_unit_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on the {partial remainder, quotient} register.
module div_step
  import div_unit_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic [2*W:0]  acc_i,
  input  logic [W-1:0]  divisor_i,
  output logic [2*W:0]  acc_o
);

  logic [W+1:0] diff;

  // acc_i[2*W:W-1] is the upper part after a one-bit left shift, with one guard bit for the sign.
  always_comb begin
    diff = acc_i[2*W:W-1] - {2'b00, divisor_i};
    if (!diff[W+1]) begin
      acc_o = {diff[W:0], acc_i[W-2:0], 1'b1};
    end else begin
      acc_o = {acc_i[2*W-1:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider: 32 restoring steps, result {remainder, quotient}.
module div_unit #(
  parameter int DATA_WIDTH = div_unit_pkg::DATA_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    signed_div_input,
  input  logic [DATA_WIDTH-1:0]   opdata1_input,
  input  logic [DATA_WIDTH-1:0]   opdata2_input,
  input  logic                    start_input,
  input  logic                    annul_input,
  output logic [2*DATA_WIDTH-1:0] result_output,
  output logic                    ready_output,
  output logic                    busy_output
);

  import div_unit_pkg::*;

  localparam int CntW = $clog2(DATA_WIDTH) + 1;

  div_state_e              state_q;
  logic [CntW-1:0]         cnt_q;
  logic [2*DATA_WIDTH:0]   acc_q;
  logic [2*DATA_WIDTH:0]   acc_d;
  logic [DATA_WIDTH-1:0]   divisor_q;
  logic                    negQuot_q;
  logic                    negRem_q;
  logic [2*DATA_WIDTH-1:0] result_q;
  logic                    ready_q;
  logic                    busy_q;

  logic                    op1Neg;
  logic                    op2Neg;
  logic [DATA_WIDTH-1:0]   mag1;
  logic [DATA_WIDTH-1:0]   mag2;
  logic [DATA_WIDTH-1:0]   quotFix;
  logic [DATA_WIDTH-1:0]   remFix;
  logic                    lastStep;

  assign op1Neg = signed_div_input & opdata1_input[DATA_WIDTH-1];
  assign op2Neg = signed_div_input & opdata2_input[DATA_WIDTH-1];
  assign mag1   = op1Neg ? (~opdata1_input + 1'b1) : opdata1_input;
  assign mag2   = op2Neg ? (~opdata2_input + 1'b1) : opdata2_input;

  div_step #(
    .W(DATA_WIDTH)
  ) u_step (
    .acc_i     (acc_q),
    .divisor_i (divisor_q),
    .acc_o     (acc_d)
  );

  // Sign correction is applied to the output of the final step so END is reached without an extra cycle.
  assign quotFix  = negQuot_q ? (~acc_d[DATA_WIDTH-1:0] + 1'b1) : acc_d[DATA_WIDTH-1:0];
  assign remFix   = negRem_q ? (~acc_d[2*DATA_WIDTH-1:DATA_WIDTH] + 1'b1)
                             : acc_d[2*DATA_WIDTH-1:DATA_WIDTH];
  assign lastStep = (cnt_q == CntW'(DATA_WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      acc_q     <= '0;
      divisor_q <= '0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        DivFree: begin
          if (start_input == DivStart && !annul_input) begin
            busy_q <= 1'b1;
            if (opdata2_input == '0) begin
              state_q <= DivByZero;
            end else begin
              state_q   <= DivOn;
              cnt_q     <= '0;
              acc_q     <= {{(DATA_WIDTH + 1){1'b0}}, mag1};
              divisor_q <= mag2;
              negQuot_q <= op1Neg ^ op2Neg;
              negRem_q  <= op1Neg;
            end
          end
        end
        DivByZero: begin
          busy_q <= 1'b0;
          if (annul_input) begin
            state_q <= DivFree;
          end else begin
            state_q  <= DivEnd;
            result_q <= '0;
            ready_q  <= DivResultReady;
          end
        end
        DivOn: begin
          if (annul_input) begin
            state_q <= DivFree;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (lastStep) begin
              state_q  <= DivEnd;
              cnt_q    <= '0;
              busy_q   <= 1'b0;
              ready_q  <= DivResultReady;
              result_q <= {remFix, quotFix};
            end
          end
        end
        DivEnd: begin
          if (start_input == DivStop) begin
            state_q  <= DivFree;
            ready_q  <= DivResultNotReady;
            result_q <= '0;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

  assign result_output = result_q;
  assign ready_output  = ready_q;
  assign busy_output   = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference model.
module tb_div_unit;

  logic        clock;
  logic        reset;
  logic        signed_div_input;
  logic [31:0] opdata1_input;
  logic [31:0] opdata2_input;
  logic        start_input;
  logic        annul_input;
  logic [63:0] result_output;
  logic        ready_output;
  logic        busy_output;

  int nCompared;
  int nMismatched;

  div_unit #(
    .DATA_WIDTH(32)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .signed_div_input (signed_div_input),
    .opdata1_input    (opdata1_input),
    .opdata2_input    (opdata2_input),
    .start_input      (start_input),
    .annul_input      (annul_input),
    .result_output    (result_output),
    .ready_output     (ready_output),
    .busy_output      (busy_output)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: plain 64-bit integer arithmetic (truncating division, remainder takes dividend's sign).
  function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Runs one operation from an IDLE negedge and leaves the DUT in IDLE at a negedge.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input int holdCycles, input string tag);
    logic [63:0] expected;
    int lat;
    int expLat;
    expected = refDiv(sgn, a, b);
    expLat = (b == 32'd0) ? 2 : 33;
    signed_div_input = sgn;
    opdata1_input = a;
    opdata2_input = b;
    start_input = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        checkOutput({tag, "_busy"}, {63'd0, busy_output}, 64'd1);
        opdata1_input = $urandom;
        opdata2_input = $urandom;
        signed_div_input = ~signed_div_input;
      end
    end while (ready_output !== 1'b1 && lat < 60);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, "_result"}, result_output, expected);
    checkOutput({tag, "_busyEnd"}, {63'd0, busy_output}, 64'd0);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clock);
      checkOutput({tag, "_holdReady"}, {63'd0, ready_output}, 64'd1);
      checkOutput({tag, "_holdResult"}, result_output, expected);
    end
    start_input = 1'b0;
    @(negedge clock);
    checkOutput({tag, "_clrReady"}, {63'd0, ready_output}, 64'd0);
    checkOutput({tag, "_clrResult"}, result_output, 64'd0);
  endtask

  initial begin
    logic sawReady;
    logic [31:0] ra, rb;
    logic rs;
    nCompared = 0;
    nMismatched = 0;
    reset = 1'b1;
    signed_div_input = 1'b0;
    opdata1_input = 32'd0;
    opdata2_input = 32'd0;
    start_input = 1'b0;
    annul_input = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_ready", {63'd0, ready_output}, 64'd0);
    checkOutput("reset_busy", {63'd0, busy_output}, 64'd0);
    checkOutput("reset_result", result_output, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    applyStimulus(1'b0, 32'd100, 32'd7, 5, "udiv_100_7");
    applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, 1, "sdiv_m7_2");
    applyStimulus(1'b0, 32'hFFFFFFF9, 32'd2, 1, "udiv_m7_2");
    applyStimulus(1'b0, 32'd55, 32'd0, 1, "div_by_zero");
    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, "sdiv_overflow");

    // Annul partway through 12345 / 3, then restart immediately with 9 / 3.
    signed_div_input = 1'b0;
    opdata1_input = 32'd12345;
    opdata2_input = 32'd3;
    start_input = 1'b1;
    sawReady = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      sawReady = sawReady | ready_output;
    end
    annul_input = 1'b1;
    start_input = 1'b0;
    @(negedge clock);
    sawReady = sawReady | ready_output;
    checkOutput("annul_busy", {63'd0, busy_output}, 64'd0);
    checkOutput("annul_noReady", {63'd0, sawReady}, 64'd0);
    annul_input = 1'b0;
    applyStimulus(1'b0, 32'd9, 32'd3, 0, "annul_restart");

    // Reset in the middle of an operation, keeping start asserted.
    opdata1_input = 32'd12345;
    opdata2_input = 32'd3;
    start_input = 1'b1;
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midReset_ready", {63'd0, ready_output}, 64'd0);
    checkOutput("midReset_busy", {63'd0, busy_output}, 64'd0);
    checkOutput("midReset_result", result_output, 64'd0);
    reset = 1'b0;
    start_input = 1'b0;
    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, "afterReset");

    // Annul in IDLE outranks start.
    opdata1_input = 32'd40;
    opdata2_input = 32'd5;
    start_input = 1'b1;
    annul_input = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("idleAnnul_busy", {63'd0, busy_output}, 64'd0);
    checkOutput("idleAnnul_ready", {63'd0, ready_output}, 64'd0);
    start_input = 1'b0;
    annul_input = 1'b0;
    @(negedge clock);

    for (int n = 0; n < 24; n++) begin
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: begin ra = $urandom; rb = 32'd0; end
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 20); end
        3: begin ra = $urandom; rb = 32'h80000000; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      applyStimulus(rs, ra, rb, $urandom_range(0, 2), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
